// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - opcode encodings shared by the lane ALU and its writeback stage
package simd_pkg;

  localparam int OPCODE_WIDTH = 4;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOOP          = 4'd0,
    OP_ADD           = 4'd1,
    OP_SUB           = 4'd2,
    OP_MUL           = 4'd3,
    OP_DOTP          = 4'd4,
    OP_STORE_TEMP_S1 = 4'd5,
    OP_STORE_TEMP_S2 = 4'd6,
    OP_STORE_RESULT  = 4'd7,
    OP_STOP          = 4'd8
  } opcode_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count and same-cycle push/pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - turns registered lane-ALU results into buffered result-memory writes
module alu_writeback #(
  parameter int OPCODE_WIDTH = 4,
  parameter int ADDR_WIDTH   = 10,
  parameter int ACC_WIDTH    = 48,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid,
  input  logic [OPCODE_WIDTH-1:0] opcode_in,
  input  logic [ADDR_WIDTH-1:0]   addr_in,
  input  logic [31:0]             alu_out,
  output logic                    stall,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [31:0]             wr_data,
  output logic                    done,
  output logic                    sat,
  output logic                    overflow
);

  import simd_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = ADDR_WIDTH + 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e                  state;
  state_e                  state_nxt;
  logic                    pend_v;
  logic [OPCODE_WIDTH-1:0] pend_op;
  logic [ADDR_WIDTH-1:0]   pend_addr;
  logic [ACC_WIDTH-1:0]    acc;
  logic [ACC_WIDTH-1:0]    acc_nxt;
  logic                    push;
  logic [31:0]             push_word;
  logic                    sat_hit;
  logic                    stop_hit;
  logic                    pop;
  logic [EW-1:0]           head;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    accept;

  assign accept   = issue_valid && (state == ST_RUN);
  assign pop      = wr_valid && wr_ready;
  assign wr_valid = !fifo_empty;
  assign wr_addr  = head[EW-1:32];
  assign wr_data  = head[31:0];
  assign done     = (state == ST_DONE);
  // One op may already be in flight when upstream sees stall, hence the -1 headroom.
  assign stall    = (fifo_count >= CW'(FIFO_DEPTH - 1)) || (state != ST_RUN);

  // Issue register mirrors the ALU's one-cycle latency; issues after STOP are not captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v    <= 1'b0;
      pend_op   <= '0;
      pend_addr <= '0;
    end else begin
      pend_v <= accept;
      if (accept) begin
        pend_op   <= opcode_in;
        pend_addr <= addr_in;
      end
    end
  end

  // Retire decode: what the op whose result is on alu_out does this cycle.
  always_comb begin
    push      = 1'b0;
    push_word = alu_out;
    acc_nxt   = acc;
    sat_hit   = 1'b0;
    stop_hit  = 1'b0;
    if (pend_v) begin
      case (pend_op)
        OP_ADD, OP_SUB, OP_MUL: begin
          push = 1'b1;
        end
        OP_DOTP: begin
          acc_nxt = acc + {{(ACC_WIDTH-32){1'b0}}, alu_out};
        end
        OP_STORE_RESULT: begin
          push    = 1'b1;
          acc_nxt = '0;
          if (|acc[ACC_WIDTH-1:32]) begin
            push_word = 32'hFFFF_FFFF;
            sat_hit   = 1'b1;
          end else begin
            push_word = acc[31:0];
          end
        end
        OP_STOP: begin
          stop_hit = 1'b1;
        end
        default: begin
          push = 1'b0;
        end
      endcase
    end
  end

  // Accumulator and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      sat      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      acc <= acc_nxt;
      if (sat_hit) begin
        sat <= 1'b1;
      end
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: STOP starts the drain, an empty buffer finishes it, DONE holds until reset.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (stop_hit) state_nxt = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_DONE;
      default:  state_nxt = ST_RUN;
    endcase
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({pend_addr, push_word}),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
